// File: rtl/parity_rx.sv
// rtl/parity_rx.sv - serial-to-parallel frame receiver with parity check and error count
module parity_rx #(
   parameter int WIDTH = 8,
   parameter int ODD   = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             serialin,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             parity_err,
   output logic [7:0]       err_count,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_PAR   = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic             ODD_BIT  = (ODD != 0);

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] shreg_q,  shreg_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic             xor_q,    xor_d;
   logic [WIDTH-1:0] data_q,   data_d;
   logic             valid_q,  valid_d;
   logic             perr_q,   perr_d;
   logic [7:0]       errcnt_q, errcnt_d;
   logic             par_mismatch;

   // The received parity bit is wrong when it differs from the running XOR, inverted for odd parity
   assign par_mismatch = (serialin != (xor_q ^ ODD_BIT));

   // Frame sequencing: start always wins over a data bit, and an unaccepted word is never overwritten
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      xor_d    = xor_q;
      data_d   = data_q;
      valid_d  = valid_q;
      perr_d   = perr_q;
      errcnt_d = errcnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_SHIFT;
               shreg_d  = '0;
               bitcnt_d = '0;
               xor_d    = 1'b0;
            end
         end
         S_SHIFT: begin
            if (start) begin
               shreg_d  = '0;
               bitcnt_d = '0;
               xor_d    = 1'b0;
            end else if (bit_valid) begin
               shreg_d = {shreg_q[WIDTH-2:0], serialin};
               xor_d   = xor_q ^ serialin;
               if (bitcnt_q == LAST_BIT) begin
                  bitcnt_d = '0;
                  state_d  = S_PAR;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end
         end
         S_PAR: begin
            if (start) begin
               state_d  = S_SHIFT;
               shreg_d  = '0;
               bitcnt_d = '0;
               xor_d    = 1'b0;
            end else if (bit_valid) begin
               data_d  = shreg_q;
               valid_d = 1'b1;
               perr_d  = par_mismatch;
               if (par_mismatch && (errcnt_q != 8'hFF)) begin
                  errcnt_d = errcnt_q + 8'd1;
               end
               state_d = S_HOLD;
            end
         end
         default: begin
            // HOLD: only an accept moves us on; a start without accept is dropped
            if (out_ready) begin
               valid_d = 1'b0;
               if (start) begin
                  state_d  = S_SHIFT;
                  shreg_d  = '0;
                  bitcnt_d = '0;
                  xor_d    = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         xor_q    <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         errcnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         xor_q    <= xor_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign data_out   = data_q;
   assign out_valid  = valid_q;
   assign parity_err = perr_q;
   assign err_count  = errcnt_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// tb/tb_parity_rx.sv - randomized and directed self-checking bench for parity_rx
module tb_parity_rx;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         bit_valid = 1'b0;
   logic         serialin = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] data_out, data_out_o;
   logic         out_valid, out_valid_o;
   logic         parity_err, parity_err_o;
   logic [7:0]   err_count, err_count_o;
   logic         busy, busy_o;

   int n_cmp = 0;
   int n_err = 0;

   bit rdy_v = 1'b1;
   bit rstn_v = 1'b0;
   bit chk_en = 1'b0;

   // inputs as sampled by the DUT at the last rising edge
   logic c_start = 1'b0, c_bv = 1'b0, c_si = 1'b0, c_rdy = 1'b0, c_rstn = 1'b0;

   // behavioural model: a queue of received bits, a pending word and two error counters
   bit         q[$];
   logic [7:0] m_data = '0;
   bit         m_valid = 0, m_active = 0, m_perr = 0, m_perr_o = 0;
   int         m_cnt = 0, m_cnt_o = 0;

   parity_rx #(.WIDTH(W), .ODD(0)) u_dut (
      .clock(clock), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
      .serialin(serialin), .data_out(data_out), .out_valid(out_valid),
      .out_ready(out_ready), .parity_err(parity_err), .err_count(err_count), .busy(busy)
   );

   parity_rx #(.WIDTH(W), .ODD(1)) u_odd (
      .clock(clock), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
      .serialin(serialin), .data_out(data_out_o), .out_valid(out_valid_o),
      .out_ready(out_ready), .parity_err(parity_err_o), .err_count(err_count_o), .busy(busy_o)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      c_start <= start;
      c_bv    <= bit_valid;
      c_si    <= serialin;
      c_rdy   <= out_ready;
      c_rstn  <= reset_n;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [7:0] d;
      int ones;
      if (!c_rstn) begin
         q.delete();
         m_data = '0; m_valid = 0; m_active = 0; m_perr = 0; m_perr_o = 0;
         m_cnt = 0; m_cnt_o = 0;
      end else if (m_valid) begin
         if (c_rdy) begin
            m_valid = 0;
            if (c_start) begin
               m_active = 1;
               q.delete();
            end
         end
      end else if (c_start) begin
         m_active = 1;
         q.delete();
      end else if (m_active && c_bv) begin
         if (q.size() < W) begin
            q.push_back(c_si);
         end else begin
            d = '0;
            foreach (q[i]) d = {d[6:0], q[i]};
            ones = $countones(d);
            m_perr   = (c_si != ones[0]);
            m_perr_o = (c_si == ones[0]);
            if (m_perr && m_cnt < 255) m_cnt++;
            if (m_perr_o && m_cnt_o < 255) m_cnt_o++;
            m_data   = d;
            m_valid  = 1;
            m_active = 0;
            q.delete();
         end
      end
   endtask

   // every falling edge: advance the model by the inputs seen at the last rising edge, then compare
   initial begin
      forever begin
         @(negedge clock);
         model_step();
         if (chk_en) begin
            chk("out_valid", out_valid, m_valid);
            chk("busy", busy, m_active || m_valid);
            chk("data_out", data_out, m_data);
            chk("parity_err", parity_err, m_perr);
            chk("err_count", err_count, m_cnt);
            chk("odd_parity_err", parity_err_o, m_perr_o);
            chk("odd_err_count", err_count_o, m_cnt_o);
            chk("odd_out_valid", out_valid_o, m_valid);
         end
      end
   end

   task automatic drive(input bit st, input bit bv, input bit si);
      @(negedge clock);
      start     = st;
      bit_valid = bv;
      serialin  = si;
      out_ready = rdy_v;
      reset_n   = rstn_v;
   endtask

   // one frame; stall idle cycles are inserted before every bit after the first
   task automatic send(input logic [7:0] d, input bit p, input int stall, input bit lit,
                       input logic [7:0] e_d, input bit e_pe, input int e_cnt);
      int lat;
      bit seen;
      drive(1'b1, 1'b0, 1'($urandom));
      lat = 0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) repeat (stall) begin
            drive(1'b0, 1'b0, 1'($urandom));
            lat++;
         end
         drive(1'b0, 1'b1, (i < 8) ? d[7-i] : p);
         lat++;
      end
      seen = 0;
      for (int j = 0; j < 60 && !seen; j++) begin
         drive(1'b0, 1'b0, 1'b0);
         lat++;
         seen = out_valid;
      end
      chk("frame_out_valid_seen", seen, 1);
      if (lit) begin
         chk("lit_latency", lat, 10 + 8 * stall);
         chk("lit_data_out", data_out, e_d);
         chk("lit_parity_err", parity_err, e_pe);
         chk("lit_err_count", err_count, e_cnt);
      end
   endtask

   initial begin
      // reset with random inputs
      rstn_v = 0;
      rdy_v  = 1;
      repeat (3) drive(1'($urandom), 1'($urandom), 1'($urandom));
      drive(1'b0, 1'b0, 1'b0);
      chk_en = 1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_err_count", err_count, 0);
      rstn_v = 1;

      send(8'hA5, 1'b0, 0, 1, 8'hA5, 1'b0, 0);
      send(8'h07, 1'b0, 0, 1, 8'h07, 1'b1, 1);
      send(8'hA5, 1'b1, 0, 1, 8'hA5, 1'b1, 2);
      chk("lit_odd_parity_err", parity_err_o, 0);
      chk("lit_odd_err_count", err_count_o, 1);
      send(8'h3C, 1'b0, 2, 1, 8'h3C, 1'b0, 2);

      // abort: three bits of 0xFF, then a fresh frame
      drive(1'b1, 1'b0, 1'b0);
      repeat (3) drive(1'b0, 1'b1, 1'b1);
      send(8'h81, 1'b0, 0, 1, 8'h81, 1'b0, 2);

      // backpressure: hold 5 cycles with a start pulse, then start in the accept cycle
      rdy_v = 0;
      send(8'h5A, 1'b0, 0, 1, 8'h5A, 1'b0, 2);
      for (int j = 0; j < 5; j++) drive(j == 2, 1'b0, 1'b0);
      chk("bp_held_valid", out_valid, 1);
      chk("bp_held_data", data_out, 8'h5A);
      rdy_v = 1;
      send(8'hC3, 1'b0, 0, 1, 8'hC3, 1'b0, 2);

      // saturation
      for (int n = 0; n < 300; n++) send(8'h07, 1'b0, 0, 0, 8'h00, 1'b0, 0);
      chk("sat_err_count", err_count, 255);
      chk("sat_parity_err", parity_err, 1);
      chk("sat_odd_err_count", err_count_o, 5);

      // reset mid-SHIFT
      drive(1'b1, 1'b0, 1'b0);
      repeat (3) drive(1'b0, 1'b1, 1'b1);
      rstn_v = 0;
      drive(1'b0, 1'b1, 1'b1);
      rstn_v = 1;
      drive(1'b0, 1'b0, 1'b0);
      chk("midrst_busy", busy, 0);
      chk("midrst_err_count", err_count, 0);
      chk("midrst_valid", out_valid, 0);
      repeat (12) drive(1'b0, 1'b1, 1'($urandom));
      chk("idle_bits_no_output", out_valid, 0);
      chk("idle_bits_busy", busy, 0);

      // randomized traffic, including aborts, stalls, backpressure and rare resets
      for (int n = 0; n < 4000; n++) begin
         rstn_v = ($urandom_range(0, 399) != 0);
         rdy_v  = 1'($urandom);
         drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
      end
      rstn_v = 1;
      rdy_v  = 1;
      repeat (3) drive(1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
